// File: rtl/hc_64_prefix_sub_pipe.sv
// hc_64_prefix_sub_pipe: two-stage pipelined 64-bit parallel-prefix subtractor.
// Computes diff = a - b - bin as a + ~b + ~bin through a hybrid prefix tree.
// S1 holds the Brent-Kung up-sweep (spans 2/4/8/16). S2 holds two Kogge-Stone
// steps on positions 31/47 and the sparse down-sweep fill.
// Position 0 of the tree carries the carry-in; position i+1 is operand bit i.
// Optional macro HC_SUB_FLAGS_EN adds registered out_zero / out_lt_s flags.
//
// Handshake: a beat moves across an interface on the rising edge where
// valid & ready are both high. Each stage owns a valid bit and loads when it is
// empty or its successor drains in the same cycle. in_ready depends
// combinationally only on out_ready and the stage valid bits.
module hc_64_prefix_sub_pipe #(
  parameter int WIDTH     = 64,
  parameter int BK_LEVELS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_ovf
`ifdef HC_SUB_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_lt_s
`endif
);

  // Stage control
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;

  // Stage 1 datapath: raw propagate and in-place up-sweep group G/P
  logic [WIDTH:1] s1_p_d, s1_p_q;
  logic [WIDTH:0] s1_gg_d, s1_gg_q;
  logic [WIDTH:0] s1_gp_d, s1_gp_q;

  // Stage 2 datapath
  logic [WIDTH:0]   s2_c;
  logic             ks_g47;
  logic             ks_p47;
  logic [WIDTH-1:0] s2_diff_d, s2_diff_q;
  logic             s2_bout_d, s2_bout_q;
  logic             s2_ovf_d, s2_ovf_q;

  // Several group-propagate bits (prefix positions, position 64) are never read
  logic unused_gp;
  assign unused_gp = ^s1_gp_q;

  // Advance conditions: a stage loads when empty or its successor drains
  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_ready = s1_adv;
  end

  // Up-sweep: after level l, position j with (j+1) % 2^(l+1) == 0 spans 2^(l+1) bits
  always_comb begin
    s1_p_d  = in_a ^ ~in_b;
    s1_gg_d = {in_a & ~in_b, ~in_bin};
    s1_gp_d = {in_a ^ ~in_b, 1'b0};
    for (int l = 0; l < BK_LEVELS; l++) begin
      for (int j = 0; j <= WIDTH; j++) begin
        if (((j + 1) % (2 << l)) == 0) begin
          s1_gg_d[j] = s1_gg_d[j] | (s1_gp_d[j] & s1_gg_d[j - (1 << l)]);
          s1_gp_d[j] = s1_gp_d[j] & s1_gp_d[j - (1 << l)];
        end
      end
    end
  end

  // Stage 1 register: data only loads on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_gg_q    <= '0;
      s1_gp_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_p_q  <= s1_p_d;
        s1_gg_q <= s1_gg_d;
        s1_gp_q <= s1_gp_d;
      end
    end
  end

  // KS steps on 31/47, prefix at 63, then down-sweep fill; s2_c[j] = carry out of position j
  always_comb begin
    s2_c     = s1_gg_q;
    ks_g47   = s1_gg_q[47] | (s1_gp_q[47] & s1_gg_q[31]);
    ks_p47   = s1_gp_q[47] & s1_gp_q[31];
    s2_c[31] = s1_gg_q[31] | (s1_gp_q[31] & s1_gg_q[15]);
    s2_c[47] = ks_g47 | (ks_p47 & s1_gg_q[15]);
    s2_c[63] = s1_gg_q[63] | (s1_gp_q[63] & s2_c[47]);
    for (int l = BK_LEVELS - 1; l >= 0; l--) begin
      for (int j = 0; j < WIDTH; j++) begin
        if ((((j + 1) % (2 << l)) == (1 << l)) && (j >= (3 << l) - 1)) begin
          s2_c[j] = s2_c[j] | (s1_gp_q[j] & s2_c[j - (1 << l)]);
        end
      end
    end
    s2_c[WIDTH] = s1_gg_q[WIDTH] | (s1_p_q[WIDTH] & s2_c[WIDTH-1]);
    s2_diff_d   = s1_p_q ^ s2_c[WIDTH-1:0];
    s2_bout_d   = ~s2_c[WIDTH];
    // When the sign bits differ, p[64]=0 and the raw g[64] equals a[63]
    s2_ovf_d    = ~s1_p_q[WIDTH] & (s1_gg_q[WIDTH] ^ s2_c[WIDTH-1]);
  end

  // Stage 2 register: result holds while the output is stalled or on bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_diff_q  <= '0;
      s2_bout_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_diff_q <= s2_diff_d;
        s2_bout_q <= s2_bout_d;
        s2_ovf_q  <= s2_ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_diff  = s2_diff_q;
  assign out_bout  = s2_bout_q;
  assign out_ovf   = s2_ovf_q;

`ifdef HC_SUB_FLAGS_EN
  logic s2_zero_q;
  logic s2_lt_s_q;

  // Flags ride with the S2 result and share its load enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero_q <= 1'b0;
      s2_lt_s_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      s2_zero_q <= ~|s2_diff_d;
      s2_lt_s_q <= s2_diff_d[WIDTH-1] ^ s2_ovf_d;
    end
  end

  assign out_zero = s2_zero_q;
  assign out_lt_s = s2_lt_s_q;
`endif

endmodule

// File: tb/tb_hc_64_prefix_sub_pipe.sv
// Bench for hc_64_prefix_sub_pipe: directed vectors, backpressure, mid-flight
// reset and a randomized stream against a behavioural subtraction model.
module tb_hc_64_prefix_sub_pipe;

  localparam int W = 66;  // {ovf, bout, diff}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_diff;
  logic        out_bout;
  logic        out_ovf;
`ifdef HC_SUB_FLAGS_EN
  logic        out_zero;
  logic        out_lt_s;
`endif

  always #5 clk = ~clk;

  hc_64_prefix_sub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout),
    .out_ovf   (out_ovf)
`ifdef HC_SUB_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_lt_s  (out_lt_s)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference: exact wide arithmetic, then read borrow and overflow off it
  function automatic logic [W-1:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic bin);
    logic [65:0] u;
    logic [65:0] s;
    u = {2'b00, a} - {2'b00, b} - {65'd0, bin};
    s = {{2{a[63]}}, a} - {{2{b[63]}}, b} - {65'd0, bin};
    return {(s[64] != s[63]), u[65], s[63:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: every cycle, sampled at the falling edge
  logic         stalled = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      check("in_ready", {127'd0, in_ready},
            {127'd0, (exp_q.size() < 2) || out_ready});
      if (stalled)
        check("stall_hold", {out_valid, out_ovf, out_bout, out_diff}, {1'b1, held});
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a, in_b, in_bin));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got diff %h with no beat expected", out_diff);
        end else begin
          check("result", {out_ovf, out_bout, out_diff}, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_ovf, out_bout, out_diff};
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat from posedge+1; returns at posedge+1 after the accepting edge
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic bin);
    logic acc;
    int   guard;
    acc      = 1'b0;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout: got in_ready=0 for 50 cycles expected 1");
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Single beat with out_ready=1: out_valid two cycles after presentation
  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input logic [W-1:0] lit);
    check({name, "_model"}, model(a, b, bin), lit);
    out_ready = 1'b1;
    drive(a, b, bin);
    check({name, "_lat1"}, {127'd0, out_valid}, 128'd0);
    @(posedge clk);
    #1;
    check({name, "_lat2"}, {127'd0, out_valid}, 128'd1);
    check({name, "_data"}, {out_ovf, out_bout, out_diff}, lit);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] bp_a[4];
    logic [63:0] bp_b[4];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_bin    = 1'b0;
    out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_data", {out_ovf, out_bout, out_diff}, 128'd0);

    directed("t1", 64'h5, 64'h3, 1'b0, {1'b0, 1'b0, 64'h2});
    directed("t2", 64'h0, 64'h1, 1'b0, {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    directed("t3", 64'h8000_0000_0000_0000, 64'h1, 1'b0,
             {1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF});
    directed("t4a", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
             {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    directed("t4b", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
             {1'b0, 1'b0, 64'h0});
    drain("t_directed_drain");

    // Backpressure: four beats while out_ready stays low for several cycles
    for (int k = 0; k < 4; k++) begin
      bp_a[k] = {$urandom, $urandom};
      bp_b[k] = {$urandom, $urandom};
    end
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          drive(bp_a[k], bp_b[k], k[0]);
          if (k == 1) begin
            @(negedge clk);
            check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
          end
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0);
    drive(64'h2, 64'h3, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    #9;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst2_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst2_data", {out_ovf, out_bout, out_diff}, 128'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst2_no_stale", {127'd0, out_valid}, 128'd0);

    // Randomized stream with random bubbles and backpressure
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pick();
      in_b      = pick();
      in_bin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
